iic_word_tx: RTL and testbench
==============================

IIC_WORD_TX -- requirements
Module: iic_word_tx

Interface
REQ-001 Parameter: CLK_DIV, default 125, clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV; 100 kHz at 50 MHz clk); legal range 2..4095.
REQ-002 Port: clk  in  1  system clock, all logic rising-edge.
REQ-003 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: iic_data  in  24  command word {slave_addr[7:0], reg_addr[7:0], reg_data[7:0]}, sent MSB first (bit 23 first).
REQ-005 Port: go  in  1  start request; a rising edge starts one transaction.
REQ-006 Port: busy  out  1  high while a transaction is in progress.
REQ-007 Port: done  out  1  sticky, set at transaction end, cleared by next accepted start.
REQ-008 Port: ack_err  out  1  sticky, set on a NACK, cleared by next accepted start.
REQ-009 Port: scl  out  1  I2C clock, idle high.
REQ-010 Port: sda_oe  out  1  open-drain enable; 1 = pull SDA low, 0 = release.
REQ-011 Port: sda_in  in  1  sampled SDA line level (already synchronized externally).

Function
REQ-012 go SHALL be registered into go_d; a start is accepted when go=1, go_d=0 and FSM is IDLE.
REQ-013 Rising edges of go while busy=1 SHALL be ignored, not queued.
REQ-014 On an accepted start: iic_data latched into a 24-bit shift register; done and ack_err cleared; busy=1 from the next cycle; quarter counter cleared.
REQ-015 iic_data changes after the start edge SHALL NOT affect the transaction in progress.
REQ-016 Quarter counter SHALL count 0..CLK_DIV-1 and emit a one-cycle tick at CLK_DIV-1; every FSM phase advance occurs only on a tick.
REQ-017 FSM states: IDLE, START, BIT, ACK, STOP.
REQ-018 IDLE: scl=1, sda_oe=0.
REQ-019 START (2 quarters): scl=1 throughout, sda_oe=1 from first quarter (SDA falls while SCL high); then BIT with bit index 23.
REQ-020 BIT (4 quarters): q0 scl=0, sda_oe=~shift[23]; q1,q2 scl=1; q3 scl=0; shift left at end of q3.
REQ-021 After bits 16, 8 and 0 (every 8th bit) FSM SHALL enter ACK instead of the next BIT.
REQ-022 ACK (4 quarters): same SCL pattern as BIT, sda_oe=0; sda_in sampled on the tick ending q2.
REQ-023 ACK sample 0: continue to next BIT, or to STOP after the third ACK.
REQ-024 ACK sample 1: ack_err set; FSM goes to STOP immediately after that ACK slot; remaining bits skipped.
REQ-025 STOP (3 quarters): q0 scl=0, sda_oe=1; q1 scl=1, sda_oe=1; q2 scl=1, sda_oe=0 (SDA rises while SCL high); then IDLE.
REQ-026 On entering IDLE from STOP: busy=0 and done=1 in the same cycle.
REQ-027 Full transaction: busy high exactly 113*CLK_DIV cycles (2+27*4+3 quarters); NACK on first ACK: 41*CLK_DIV cycles.
REQ-028 SDA SHALL change only while scl=0, except in START and STOP.

Reset
REQ-029 While reset_n=0: FSM IDLE, scl=1, sda_oe=0, busy=0, done=0, ack_err=0, counter=0, shift register=0.
REQ-030 go_d SHALL reset to 1 so go held high across reset release does not start a transaction.
REQ-031 Reset mid-transaction SHALL abort immediately to REQ-029 values with no STOP generated.

Verification
REQ-032 CLK_DIV=4, iic_data=0x341E00, slave model ACKs all -> SDA decodes 0x34,0x1E,0x00 with START/STOP, busy high 452 cycles, done=1, ack_err=0.
REQ-033 CLK_DIV=4, slave NACKs address byte -> ack_err=1, done=1, only 9 SCL pulses, STOP issued, busy high 164 cycles.
REQ-034 Second go rising edge 100 cycles into a transfer, iic_data changed to 0xFFFFFF -> ignored; bus still carries original word; one transaction only.
REQ-035 reset_n pulsed low at cycle 200 of a transfer -> scl=1, sda_oe=0, busy=0, done=0 asynchronously; next go edge runs a clean full transaction.
REQ-036 go held high during reset and after release -> no transaction; go low then high -> one transaction.
REQ-037 Back-to-back: go edge on the cycle after done rises -> accepted, done and ack_err cleared next cycle, second word sent correctly.

Source files
------------

// File: rtl/iic_word_tx.sv
// iic_word_tx: write-only I2C master that sends one 24-bit command word
// {slave_addr, reg_addr, reg_data} per go rising edge. SCL is built from
// CLK_DIV-cycle quarter periods. An ACK slot follows every byte, and a NACK
// ends the transfer with a STOP.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | bus released, waiting for a go rising edge
// S_START | 2 quarters, SDA pulled low while SCL stays high
// S_BIT   | 4 quarters per data bit, MSB of shift register on SDA
// S_ACK   | 4 quarters, SDA released, slave response sampled at end of q2
// S_STOP  | 3 quarters, SDA released while SCL high, then back to idle
module iic_word_tx #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] iic_data,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_in
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  localparam logic [11:0] QMAX = 12'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_go_d;
  logic [11:0] r_qcnt;
  logic [1:0]  r_quarter;
  logic [4:0]  r_bit_idx;
  logic [23:0] r_shift;
  logic        r_done;
  logic        r_ack_err;
  logic        w_accept;
  logic        w_tick;

  // go_d resets high so a go held across reset release is not a start
  assign w_accept = go & ~r_go_d & (r_state == S_IDLE);
  assign w_tick   = (r_state != S_IDLE) && (r_qcnt == QMAX);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; every phase advance waits for a quarter tick
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_START;
      S_START: if (w_tick && r_quarter == 2'd1) w_state_nxt = S_BIT;
      S_BIT:   if (w_tick && r_quarter == 2'd3 && r_bit_idx[2:0] == 3'd0)
                 w_state_nxt = S_ACK;
      S_ACK:   if (w_tick && r_quarter == 2'd3) begin
                 // r_ack_err was captured one quarter earlier, at the end of q2
                 if (r_ack_err || r_bit_idx == 5'd0) w_state_nxt = S_STOP;
                 else                                w_state_nxt = S_BIT;
               end
      S_STOP:  if (w_tick && r_quarter == 2'd2) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Quarter timing, shift register, bit index and sticky status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_go_d    <= 1'b1;
      r_qcnt    <= 12'd0;
      r_quarter <= 2'd0;
      r_bit_idx <= 5'd0;
      r_shift   <= 24'd0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_go_d <= go;
      if (w_accept) begin
        r_shift   <= iic_data;
        r_done    <= 1'b0;
        r_ack_err <= 1'b0;
        r_qcnt    <= 12'd0;
        r_quarter <= 2'd0;
        r_bit_idx <= 5'd23;
      end else if (r_state != S_IDLE) begin
        r_qcnt <= w_tick ? 12'd0 : r_qcnt + 12'd1;
        if (w_tick) begin
          // BIT->BIT wraps 3->0 on its own; any state change restarts at q0
          r_quarter <= (w_state_nxt != r_state) ? 2'd0 : r_quarter + 2'd1;
          if (r_state == S_BIT && r_quarter == 2'd3) begin
            r_shift <= {r_shift[22:0], 1'b0};
            // bits 16, 8 and 0 keep their index until the following ACK ends
            if (r_bit_idx[2:0] != 3'd0) r_bit_idx <= r_bit_idx - 5'd1;
          end
          if (r_state == S_ACK && r_quarter == 2'd2 && sda_in) r_ack_err <= 1'b1;
          if (r_state == S_ACK && r_quarter == 2'd3 && r_bit_idx != 5'd0)
            r_bit_idx <= r_bit_idx - 5'd1;
          if (r_state == S_STOP && r_quarter == 2'd2) r_done <= 1'b1;
        end
      end
    end
  end

  // Bus outputs decoded from state and quarter
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    busy   = (r_state != S_IDLE);
    case (r_state)
      S_START: sda_oe = 1'b1;
      S_BIT: begin
        scl    = (r_quarter == 2'd1) || (r_quarter == 2'd2);
        sda_oe = ~r_shift[23];
      end
      S_ACK:   scl = (r_quarter == 2'd1) || (r_quarter == 2'd2);
      S_STOP: begin
        scl    = (r_quarter != 2'd0);
        sda_oe = (r_quarter != 2'd2);
      end
      default: begin
        scl    = 1'b1;
        sda_oe = 1'b0;
      end
    endcase
  end

  assign done    = r_done;
  assign ack_err = r_ack_err;

endmodule

// File: tb/tb_iic_word_tx.sv
// Bench for iic_word_tx at CLK_DIV=4: a slave model decodes bytes from the
// bus and compares them with a queue of expected bytes. Expected per-transfer
// busy length and status are queued when go is driven and checked when busy
// falls.
module tb_iic_word_tx;

  localparam int CLK_DIV = 4;

  typedef struct {
    int   len;
    logic aerr;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] iic_data = 24'd0;
  logic        go = 1'b1;
  logic        busy, done, ack_err, scl, sda_oe;
  logic        sda_in;

  logic        pull = 1'b0;
  int          slave_nack_at = 3;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_bytes[$];
  txn_t       exp_txn[$];

  int   rise = 0;
  int   starts = 0;
  int   stops = 0;
  int   last_pulses = 0;
  int   busy_cnt = 0;
  int   txn_cnt = 0;
  logic prev_scl = 1'b1;
  logic prev_line = 1'b1;
  logic prev_busy = 1'b0;
  logic line;
  logic [7:0] sh = 8'd0;

  assign sda_in = ~sda_oe & ~pull;

  iic_word_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .iic_data(iic_data),
    .go      (go),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl     (scl),
    .sda_oe  (sda_oe),
    .sda_in  (sda_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave model and bus monitor, sampled away from the DUT's active edge
  always @(negedge clk) begin
    if (!reset_n) begin
      rise      = 0;
      pull      = 1'b0;
      busy_cnt  = 0;
      prev_busy = 1'b0;
      prev_scl  = 1'b1;
      prev_line = 1'b1;
    end else begin
      line = ~sda_oe & ~pull;
      if (prev_scl && scl && prev_line && !line) begin
        starts++;
        rise = 0;
        sh   = 8'd0;
      end else if (prev_scl && scl && !prev_line && line) begin
        stops++;
        last_pulses = rise - 1;
      end
      if (!prev_scl && scl) begin
        rise++;
        if (rise % 9 != 0) begin
          sh = {sh[6:0], line};
          if (rise % 9 == 8) begin
            if (exp_bytes.size() == 0) chk("byte_queue_size", 32'(exp_bytes.size()), 32'd1);
            else chk("byte", 32'(sh), 32'(exp_bytes.pop_front()));
          end
        end
      end
      if (prev_scl && !scl)
        pull = (rise % 9 == 8) && ((rise / 9) != slave_nack_at);
      if (busy) busy_cnt++;
      if (busy && !prev_busy) txn_cnt++;
      if (!busy && prev_busy) begin
        if (exp_txn.size() == 0) chk("txn_queue_size", 32'(exp_txn.size()), 32'd1);
        else begin
          txn_t t;
          t = exp_txn.pop_front();
          chk("busy_len", 32'(busy_cnt), 32'(t.len));
          chk("done_at_end", 32'(done), 32'd1);
          chk("ack_err_at_end", 32'(ack_err), 32'(t.aerr));
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
      prev_scl  = scl;
      prev_line = line;
    end
  end

  task automatic start_txn(input logic [23:0] d, input int nk, input bit now);
    txn_t t;
    if (!now) begin
      @(posedge clk);
      #1;
    end
    slave_nack_at = nk;
    iic_data = d;
    go = 1'b1;
    for (int i = 0; i < 3 && i <= nk; i++) exp_bytes.push_back(d[23-8*i -: 8]);
    t.len  = (nk >= 3) ? 113 * CLK_DIV : (2 + (nk + 1) * 36 + 3) * CLK_DIV;
    t.aerr = (nk < 3);
    exp_txn.push_back(t);
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n_before;
    // go held high through reset and after release: nothing may start
    repeat (5) @(posedge clk);
    #1;
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("go_held_busy", 32'(busy), 32'd0);
    chk("go_held_txn", 32'(txn_cnt), 32'd0);
    go = 1'b0;

    // full transaction, all bytes acknowledged
    start_txn(24'h341E00, 3, 0);
    wait_idle(600);
    chk("full_pulses", 32'(last_pulses), 32'd27);

    // slave NACKs the address byte
    start_txn(24'hA55AC3, 0, 0);
    wait_idle(600);
    chk("nack_pulses", 32'(last_pulses), 32'd9);

    // second go edge mid-transfer with new data must be ignored
    n_before = txn_cnt;
    start_txn(24'h123456, 3, 0);
    repeat (99) @(posedge clk);
    #1;
    iic_data = 24'hFFFFFF;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    wait_idle(600);
    repeat (20) @(posedge clk);
    #1;
    chk("ignored_go_busy", 32'(busy), 32'd0);
    chk("ignored_go_txns", 32'(txn_cnt - n_before), 32'd1);

    // reset about 200 cycles into a transfer; only the address byte completes
    start_txn(24'h55AA0F, 3, 0);
    void'(exp_txn.pop_back());
    void'(exp_bytes.pop_back());
    void'(exp_bytes.pop_back());
    repeat (199) @(posedge clk);
    #1;
    chk("busy_before_rst", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_scl", 32'(scl), 32'd1);
    chk("abort_sda_oe", 32'(sda_oe), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    start_txn(24'h9C3E71, 3, 0);
    wait_idle(600);
    chk("post_rst_ack_err", 32'(ack_err), 32'd0);

    // NACK on the second byte, then a go edge the cycle after done rises
    start_txn(24'h3C81F0, 1, 0);
    wait_idle(600);
    chk("b2b_first_ack_err", 32'(ack_err), 32'd1);
    chk("b2b_first_done", 32'(done), 32'd1);
    start_txn(24'hC0FFEE, 3, 1);
    chk("b2b_done_clr", 32'(done), 32'd0);
    chk("b2b_ack_err_clr", 32'(ack_err), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_idle(600);
    repeat (5) @(posedge clk);
    #1;

    chk("starts", 32'(starts), 32'd7);
    chk("stops", 32'(stops), 32'd6);
    chk("txn_count", 32'(txn_cnt), 32'd7);
    chk("bytes_left", 32'(exp_bytes.size()), 32'd0);
    chk("txns_left", 32'(exp_txn.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
